// File: rtl/ntt_demux_pkg.sv
// Shared definitions for the NTT lane demultiplexer: default geometry and
// the helper that locates a lane inside the flat output bus.
package ntt_demux_pkg;

  localparam int NTT_N_DEF = 9;
  localparam int NTT_S_DEF = 3;

  // Lane k occupies bits [k*n +: n] of the packed bus, lane 0 in the LSBs.
  function automatic int lane_lo(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/ntt_demux_if.sv
// Bus bundle between a word producer and the per-lane consumers.
// master drives the word/select side, slave (the demux) drives the lanes.
interface ntt_demux_if
  import ntt_demux_pkg::*;
#(
  parameter int N = NTT_N_DEF,
  parameter int S = NTT_S_DEF
);

  localparam int SEL_W = $clog2(S);

  logic [N-1:0]     a;
  logic [SEL_W-1:0] sel;
  logic             valid_in;
  logic [S*N-1:0]   s;
  logic [S-1:0]     valid_out;

  modport master (
    output a, sel, valid_in,
    input  s, valid_out
  );

  modport slave (
    input  a, sel, valid_in,
    output s, valid_out
  );

endinterface

// File: rtl/ntt_demux_decode.sv
// Select decoder for the lane demux: turns sel/valid_in into a one-hot lane
// enable. A select that names no existing lane yields an all-zero enable.
module ntt_demux_decode #(
  parameter int S     = 3,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             valid_in,
  output logic [S-1:0]     en
);

  // Compare sel against every real lane index, so sel >= S matches nothing.
  always_comb begin
    en = '0;
    for (int k = 0; k < S; k++) begin
      en[k] = valid_in && (int'(sel) == k);
    end
  end

endmodule

// File: rtl/ntt_demux.sv
// Registered 1-to-S demultiplexer: one N-bit word per cycle is steered into
// one lane of a flat S*N bus; every other lane reads zero. One cycle latency,
// asynchronous active-high reset clears all lanes and strobes.
module ntt_demux
  import ntt_demux_pkg::*;
#(
  parameter int N = NTT_N_DEF,
  parameter int S = NTT_S_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ntt_demux_if.slave  bus
);

  localparam int SEL_W = $clog2(S);

  logic [S-1:0] en;
  logic [S-1:0] valid_out_d;
  logic [S-1:0] valid_out_q;

  ntt_demux_decode #(
    .S     (S),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel      (bus.sel),
    .valid_in (bus.valid_in),
    .en       (en)
  );

  // The lane strobe is simply the registered one-hot enable.
  always_comb valid_out_d = en;

  // Strobe register; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_out_q <= '0;
    else     valid_out_q <= valid_out_d;
  end

  assign bus.valid_out = valid_out_q;

  for (genvar k = 0; k < S; k++) begin : g_lane
    logic [N-1:0] lane_d;
    logic [N-1:0] lane_q;

    // Non-selected lanes load zero so no stale data lingers on the bus.
    always_comb lane_d = en[k] ? bus.a : '0;

    // Per-lane output register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) lane_q <= '0;
      else     lane_q <= lane_d;
    end

    assign bus.s[lane_lo(k, N) +: N] = lane_q;
  end

endmodule

// File: tb/tb_ntt_demux.sv
// Self-checking bench for ntt_demux: a 9-bit/3-lane instance for the main
// behaviour and a 16-bit/4-lane instance for the width case.
module tb_ntt_demux;
  import ntt_demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_demux_if #(.N(9),  .S(3)) bus   ();
  ntt_demux_if #(.N(16), .S(4)) bus_w ();

  ntt_demux #(.N(9), .S(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ntt_demux #(.N(16), .S(4)) u_wide (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  typedef struct packed {
    logic [63:0] s;
    logic [7:0]  vo;
  } exp_t;

  exp_t q_main[$];
  exp_t q_wide[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the selected lane holds a, everything else is zero.
  function automatic exp_t model(input int n, input int s, input logic [15:0] a,
                                 input int sel, input logic v);
    exp_t e;
    e = '0;
    if (v && sel < s) begin
      e.s  = 64'(a) << (sel * n);
      e.vo = 8'(1) << sel;
    end
    return e;
  endfunction

  task automatic step(input logic [8:0] a, input int sel, input logic v, input string tag);
    exp_t e;
    @(negedge clk);
    bus.a        = a;
    bus.sel      = 2'(sel);
    bus.valid_in = v;
    q_main.push_back(model(9, 3, {7'b0, a}, sel, v));
    @(posedge clk);
    #1;
    if (q_main.size() == 0) begin
      chk({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      e = q_main.pop_front();
      chk({tag, "_s"},  64'(bus.s),         e.s);
      chk({tag, "_vo"}, 64'(bus.valid_out), 64'(e.vo));
    end
  endtask

  task automatic step_w(input logic [15:0] a, input int sel, input logic v, input string tag);
    exp_t e;
    @(negedge clk);
    bus_w.a        = a;
    bus_w.sel      = 2'(sel);
    bus_w.valid_in = v;
    q_wide.push_back(model(16, 4, a, sel, v));
    @(posedge clk);
    #1;
    if (q_wide.size() == 0) begin
      chk({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      e = q_wide.pop_front();
      chk({tag, "_s"},  bus_w.s,                e.s);
      chk({tag, "_vo"}, 64'(bus_w.valid_out),   64'(e.vo));
    end
  endtask

  initial begin
    bus.a = '0;   bus.sel = '0;   bus.valid_in = 1'b0;
    bus_w.a = '0; bus_w.sel = '0; bus_w.valid_in = 1'b0;

    // Reset with live inputs, checked before the first clock edge.
    #1;
    rst = 1'b1;
    bus.a = 9'h0FF; bus.sel = 2'd1; bus.valid_in = 1'b1;
    #2;
    chk("rst_async_s",  64'(bus.s),         64'd0);
    chk("rst_async_vo", 64'(bus.valid_out), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_s",  64'(bus.s),         64'd0);
    chk("rst_hold_vo", 64'(bus.valid_out), 64'd0);
    rst = 1'b0;

    // Lane sweep.
    step(9'h00F, 0, 1'b1, "sweep0");
    step(9'h00F, 1, 1'b1, "sweep1");
    step(9'h00F, 2, 1'b1, "sweep2");

    // Out-of-range select, then wrap to lane 0.
    step(9'h1FF, 3, 1'b1, "oor3");
    step(9'h1FF, 0, 1'b1, "wrap0");

    // valid_in gating.
    step(9'h155, 2, 1'b0, "gate_off");
    step(9'h155, 2, 1'b1, "gate_on");

    // Back-to-back alternating lanes.
    for (int i = 0; i < 4; i++) begin
      step((i % 2) ? 9'h100 : 9'h001, i % 2, 1'b1, "b2b");
    end

    // Mid-stream reset pulse between edges; outputs are nonzero going in.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_s",  64'(bus.s),         64'd0);
    chk("mid_rst_vo", 64'(bus.valid_out), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_edge_s",  64'(bus.s),         64'd0);
    chk("mid_rst_edge_vo", 64'(bus.valid_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(9'h001, 0, 1'b1, "resume0");
    step(9'h100, 1, 1'b1, "resume1");

    // Random traffic including out-of-range selects and idle cycles.
    for (int i = 0; i < 12; i++) begin
      step(9'($urandom_range(0, 511)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), "rand");
    end

    // Wide instance.
    step_w(16'hABCD, 3, 1'b1, "wide3");
    step_w(16'h1234, 0, 1'b1, "wide0");
    step_w(16'hFFFF, 2, 1'b0, "wide_off");
    step_w(16'h8001, 1, 1'b1, "wide1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
